alb_norm_stage: RTL and testbench

//   Registered post-ALB normalisation stage: captures one 10-bit ALB result F and its flags, then optionally

---
 rtl/alb_norm_stage_if.sv | 26 ++
 rtl/alb_norm_stage.sv | 57 +++++
 tb/tb_alb_norm_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alb_norm_stage_if.sv
// alb_norm_stage_if: upstream/downstream handshake bundle for the normalisation stage
interface alb_norm_stage_if #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_f;
  logic [3:0]       in_flags;
  logic             in_norm_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic [CNT_W-1:0] out_shift;
  logic [3:0]       out_flags;
  logic             out_zero;
  logic             busy;
  modport master (
    output in_valid, in_f, in_flags, in_norm_en, out_ready,
    input  in_ready, out_valid, out_f, out_shift, out_flags, out_zero, busy
  );
  modport slave (
    input  in_valid, in_f, in_flags, in_norm_en, out_ready,
    output in_ready, out_valid, out_f, out_shift, out_flags, out_zero, busy
  );
endinterface

// File: rtl/alb_norm_stage.sv
// alb_norm_stage: registered ALB result normaliser, one left shift per clock until MSB is set
module alb_norm_stage #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  alb_norm_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       flg;
  logic             zero;
  logic             acc;
  assign acc = (state == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_f     = data;
  assign bus.out_shift = cnt;
  assign bus.out_flags = flg;
  assign bus.out_zero  = zero;
  // next state: shift only non-zero results that are not yet normalised
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !bus.in_valid ? IDLE :
                     (bus.in_norm_en && bus.in_f != '0 && !bus.in_f[WIDTH-1]) ? SHIFT : DONE;
      SHIFT:   nxt = data[WIDTH-2] ? DONE : SHIFT;
      DONE:    nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // state and result registers; capture on accept, shift while in SHIFT, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      flg   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        data <= bus.in_f;
        cnt  <= '0;
        flg  <= bus.in_flags;
        zero <= (bus.in_f == '0);
      end else if (state == SHIFT) begin
        data <= {data[WIDTH-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alb_norm_stage.sv
// tb_alb_norm_stage: directed and randomized checks of alb_norm_stage against an arithmetic model
module tb_alb_norm_stage;
  localparam int W = 10;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  alb_norm_stage_if #(.WIDTH(W), .CNT_W(C)) bus ();
  alb_norm_stage #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_out(input string tag, input int ef, input int ek, input int efl, input int ez);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_f"}, 32'(bus.out_f), 32'(ef));
    check({tag, "_shift"}, 32'(bus.out_shift), 32'(ek));
    check({tag, "_flags"}, 32'(bus.out_flags), 32'(efl));
    check({tag, "_zero"}, 32'(bus.out_zero), 32'(ez));
  endtask
  // reference: shift by plain doubling until the value reaches the MSB weight
  task automatic model(input int f, input bit en, output int ef, output int ek);
    ef = f;
    ek = 0;
    if (en && f != 0)
      while (ef < (1 << (W - 1))) begin
        ef = ef * 2;
        ek++;
      end
  endtask
  task automatic txn(input string tag, input int f, input int fl, input bit en, input int hold);
    int ef, ek, lat;
    model(f, en, ef, ek);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_f = W'(f);
    bus.in_flags = 4'(fl);
    bus.in_norm_en = en;
    @(posedge clk); #1;
    bus.in_f = W'($urandom);
    bus.in_flags = 4'($urandom);
    bus.in_norm_en = 1'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check({tag, "_busy_ready"}, {30'd0, bus.busy, bus.in_ready}, 32'b10);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(1 + ek));
    for (int i = 0; i < hold; i++) begin
      check_out({tag, "_hold"}, ef, ek, fl, f == 0);
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    check_out(tag, ef, ek, fl, f == 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, "_after_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_after_ready"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_f = '0;
    bus.in_flags = '0;
    bus.in_norm_en = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_ready", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_f", 32'(bus.out_f), 0);
    check("rst_shift", 32'(bus.out_shift), 0);
    check("rst_flags", 32'(bus.out_flags), 0);
    check("rst_zero", 32'(bus.out_zero), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    txn("sel00", 10'b1011101110, 4'b0000, 1'b1, 0);
    txn("sel01", 10'b0000010001, 4'b0101, 1'b1, 0);
    txn("sel01_pass", 10'b0000010001, 4'b1010, 1'b0, 0);
    txn("zero", 0, 4'b0001, 1'b1, 0);
    txn("zero_pass", 0, 4'b0011, 1'b0, 1);
    txn("lsb_only", 1, 4'b0110, 1'b1, 0);
    txn("sel11", 10'b0111110001, 4'b0010, 1'b1, 3);
    bus.in_valid = 1'b1;
    bus.in_f = 10'b0111110001;
    bus.in_flags = 4'b1111;
    bus.in_norm_en = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ready", 32'(bus.in_ready), 1);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_f", 32'(bus.out_f), 0);
    for (int i = 0; i < 3; i++) begin
      check("mrst_novalid", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 40; i++) begin
      int f;
      f = int'($urandom_range(0, (1 << W) - 1));
      case ($urandom_range(0, 3))
        0: f = 0;
        1: f = f >> $urandom_range(1, W - 1);
        default: ;
      endcase
      txn("rand", f, int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
